axi_cfg_sequencer: RTL and testbench



---
 rtl/axi_cfg_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_axi_cfg_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_cfg_sequencer.sv
// AXI4-Lite master: writes config registers 1..CFG_WORDS, triggers via register 0,
// then polls the status register until DONE_CODE appears or POLL_LIMIT reads expire.
module axi_cfg_sequencer #(
  parameter int         DATA_WIDTH   = 32,
  parameter int         ADDR_WIDTH   = 32,
  parameter int         CFG_WORDS    = 4,
  parameter int         STATUS_INDEX = 5,
  parameter logic [2:0] DONE_CODE    = 3'b100,
  parameter int         POLL_GAP     = 8,
  parameter int         POLL_LIMIT   = 1024
) (
  input  logic                            clk,
  input  logic                            areset,
  input  logic                            start_i,
  input  logic [CFG_WORDS*DATA_WIDTH-1:0] cfg_data_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            err_o,
  output logic [1:0]                      err_code_o,
  output logic [2:0]                      status_o,
  output logic [ADDR_WIDTH-1:0]           awaddr_o,
  output logic                            awvalid_o,
  input  logic                            awready_i,
  output logic [DATA_WIDTH-1:0]           wdata_o,
  output logic [3:0]                      wstrb_o,
  output logic                            wvalid_o,
  input  logic                            wready_i,
  input  logic [1:0]                      bresp_i,
  input  logic                            bvalid_i,
  output logic                            bready_o,
  output logic [ADDR_WIDTH-1:0]           araddr_o,
  output logic                            arvalid_o,
  input  logic                            arready_i,
  input  logic [DATA_WIDTH-1:0]           rdata_i,
  input  logic                            rvalid_i,
  output logic                            rready_o
);

  localparam int IW = $clog2(CFG_WORDS + 1);
  localparam int PW = $clog2(POLL_LIMIT + 1);
  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [IW-1:0]         LAST_IDX    = IW'(CFG_WORDS);
  localparam logic [PW-1:0]         POLL_MAX    = PW'(POLL_LIMIT);
  localparam logic [GW-1:0]         GAP_LAST    = GW'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
  localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = ADDR_WIDTH'(STATUS_INDEX * 4);

  typedef enum logic [2:0] {
    IDLE, WR, WR_RESP, POLL_AR, POLL_R, POLL_WAIT, FINISH
  } state_t;

  state_t                          r_state;
  logic [CFG_WORDS*DATA_WIDTH-1:0] r_shadow;
  logic [IW-1:0]                   r_index;
  logic [PW-1:0]                   r_poll_cnt;
  logic [GW-1:0]                   r_gap_cnt;

  logic [IW-1:0] w_index_nxt;
  logic [PW-1:0] w_poll_nxt;
  logic          w_aw_done;
  logic          w_w_done;
  logic          w_unused;

  assign w_index_nxt = r_index + 1'b1;
  assign w_poll_nxt  = r_poll_cnt + 1'b1;
  assign w_aw_done   = !awvalid_o || awready_i;
  assign w_w_done    = !wvalid_o || wready_i;
  assign w_unused    = &{1'b0, rdata_i[DATA_WIDTH-1:3]};

  // The shadow is a shift register: its low word is always the next config word to send.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_state    <= IDLE;
      r_shadow   <= '0;
      r_index    <= '0;
      r_poll_cnt <= '0;
      r_gap_cnt  <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= 2'd0;
      status_o   <= 3'd0;
      awaddr_o   <= '0;
      awvalid_o  <= 1'b0;
      wdata_o    <= '0;
      wstrb_o    <= 4'h0;
      wvalid_o   <= 1'b0;
      bready_o   <= 1'b0;
      araddr_o   <= '0;
      arvalid_o  <= 1'b0;
      rready_o   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_shadow   <= cfg_data_i >> DATA_WIDTH;
            r_index    <= IW'(1);
            r_poll_cnt <= '0;
            err_code_o <= 2'd0;
            busy_o     <= 1'b1;
            awaddr_o   <= ADDR_WIDTH'(4);
            wdata_o    <= cfg_data_i[DATA_WIDTH-1:0];
            wstrb_o    <= 4'hF;
            awvalid_o  <= 1'b1;
            wvalid_o   <= 1'b1;
            r_state    <= WR;
          end
        end
        WR: begin
          if (awready_i) awvalid_o <= 1'b0;
          if (wready_i)  wvalid_o  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            bready_o <= 1'b1;
            r_state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid_i) begin
            bready_o <= 1'b0;
            if (bresp_i != 2'd0) begin
              err_code_o <= 2'd1;
              err_o      <= 1'b1;
              busy_o     <= 1'b0;
              r_state    <= FINISH;
            end else if (r_index == '0) begin
              araddr_o  <= STATUS_ADDR;
              arvalid_o <= 1'b1;
              r_state   <= POLL_AR;
            end else if (r_index < LAST_IDX) begin
              r_index   <= w_index_nxt;
              awaddr_o  <= ADDR_WIDTH'(w_index_nxt) << 2;
              wdata_o   <= r_shadow[DATA_WIDTH-1:0];
              r_shadow  <= r_shadow >> DATA_WIDTH;
              awvalid_o <= 1'b1;
              wvalid_o  <= 1'b1;
              r_state   <= WR;
            end else begin
              r_index   <= '0;
              awaddr_o  <= '0;
              wdata_o   <= DATA_WIDTH'(1);
              awvalid_o <= 1'b1;
              wvalid_o  <= 1'b1;
              r_state   <= WR;
            end
          end
        end
        POLL_AR: begin
          if (arready_i) begin
            arvalid_o <= 1'b0;
            rready_o  <= 1'b1;
            r_state   <= POLL_R;
          end
        end
        POLL_R: begin
          if (rvalid_i) begin
            rready_o   <= 1'b0;
            status_o   <= rdata_i[2:0];
            r_poll_cnt <= w_poll_nxt;
            if (rdata_i[2:0] == DONE_CODE) begin
              done_o  <= 1'b1;
              busy_o  <= 1'b0;
              r_state <= FINISH;
            end else if (w_poll_nxt == POLL_MAX) begin
              err_code_o <= 2'd2;
              err_o      <= 1'b1;
              busy_o     <= 1'b0;
              r_state    <= FINISH;
            end else if (POLL_GAP == 0) begin
              arvalid_o <= 1'b1;
              r_state   <= POLL_AR;
            end else begin
              r_gap_cnt <= '0;
              r_state   <= POLL_WAIT;
            end
          end
        end
        POLL_WAIT: begin
          if (r_gap_cnt == GAP_LAST) begin
            arvalid_o <= 1'b1;
            r_state   <= POLL_AR;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        FINISH: begin
          done_o  <= 1'b0;
          err_o   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_cfg_sequencer.sv
// Directed bench for axi_cfg_sequencer: a negedge-driven AXI4-Lite slave model with
// configurable AW latency, write error injection and status sequencing, plus a vector table.
module tb_axi_cfg_sequencer;

  logic         clk = 1'b0;
  logic         areset = 1'b1;
  logic         start_i = 1'b0;
  logic [127:0] cfg_data_i = '0;
  logic         busy_o, done_o, err_o;
  logic [1:0]   err_code_o;
  logic [2:0]   status_o;
  logic [31:0]  awaddr_o, wdata_o, araddr_o;
  logic [3:0]   wstrb_o;
  logic         awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o;
  logic         awready_i = 1'b0, wready_i = 1'b0, bvalid_i = 1'b0;
  logic         arready_i = 1'b0, rvalid_i = 1'b0;
  logic [1:0]   bresp_i = 2'd0;
  logic [31:0]  rdata_i = '0;

  axi_cfg_sequencer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .CFG_WORDS(4), .STATUS_INDEX(5),
    .DONE_CODE(3'b100), .POLL_GAP(2), .POLL_LIMIT(4)
  ) dut (
    .clk(clk), .areset(areset), .start_i(start_i), .cfg_data_i(cfg_data_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o),
    .status_o(status_o),
    .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rdata_i(rdata_i), .rvalid_i(rvalid_i), .rready_o(rready_o)
  );

  always #5 clk = ~clk;

  // Slave model configuration (written by the test) and observation logs (written by the slave)
  int aw_lat = 1, err_wr = 0, done_at = 3;
  logic [31:0] aw_addr_q[$], w_data_q[$], ar_addr_q[$];
  int ar_cyc_q[$];
  int cyc = 0, last_fire = 0, b_hs = 0, r_hs = 0, aw_hi = 0, w_hi = 0;
  int wr_num = 0, rd_num = 0, aw_wait = 0;
  logic b_arm = 0, ar_arm = 0, b_fire = 0, r_fire = 0, aw_got = 0, w_got = 0;
  logic [1:0] b_resp_nxt = 2'd0;

  // Values set here are what the DUT sees at the following posedge, so handshakes are logged now.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (areset) begin
      awready_i = 0; wready_i = 0; bvalid_i = 0; bresp_i = 0;
      arready_i = 0; rvalid_i = 0; rdata_i = 0;
      b_arm = 0; ar_arm = 0; b_fire = 0; r_fire = 0; aw_got = 0; w_got = 0;
      aw_wait = 0; wr_num = 0; rd_num = 0;
    end else begin
      if (done_o || err_o) begin wr_num = 0; rd_num = 0; end
      if (b_fire) begin bvalid_i = 0; bresp_i = 0; end
      if (r_fire) begin rvalid_i = 0; rdata_i = 0; end
      if (b_arm) begin bvalid_i = 1; bresp_i = b_resp_nxt; b_arm = 0; end
      if (ar_arm) begin
        rvalid_i = 1;
        rdata_i  = (rd_num == done_at) ? 32'h1234_5674 : 32'h0000_0009;
        ar_arm   = 0;
      end
      awready_i = awvalid_o && (aw_wait + 1 >= aw_lat);
      wready_i  = wvalid_o;
      arready_i = arvalid_o;
      if (awvalid_o) aw_hi++;
      if (wvalid_o) w_hi++;
      if (awvalid_o && !awready_i) aw_wait++;
      if (awvalid_o && awready_i) begin aw_addr_q.push_back(awaddr_o); aw_wait = 0; aw_got = 1; end
      if (wvalid_o && wready_i) begin w_data_q.push_back(wdata_o); w_got = 1; end
      if (aw_got && w_got) begin
        aw_got = 0; w_got = 0; wr_num++; b_arm = 1;
        b_resp_nxt = (wr_num == err_wr) ? 2'd2 : 2'd0;
      end
      b_fire = bvalid_i && bready_o;
      if (b_fire) begin b_hs++; last_fire = cyc; end
      if (arvalid_o && arready_i) begin
        ar_addr_q.push_back(araddr_o); ar_cyc_q.push_back(cyc); rd_num++; ar_arm = 1;
      end
      r_fire = rvalid_i && rready_o;
      if (r_fire) begin r_hs++; last_fire = cyc; end
    end
  end

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_end(input string name);
    bit seen = 0;
    for (int i = 0; i < 300; i++) begin
      if (done_o || err_o) begin seen = 1; break; end
      step();
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: no done/err pulse within 300 cycles", name);
    end
  endtask

  task automatic run_job(input logic [127:0] cfg, input string name);
    step(); cfg_data_i = cfg; start_i = 1;
    step(); start_i = 0;
    chk({name, "_busy_rise"}, busy_o, 1);
    wait_end(name);
    chk({name, "_pulse_latency"}, cyc, last_fire + 1);
  endtask

  task automatic chk_writes(input string name, input int awb, input int wb, input int n,
                            input logic [127:0] cfg);
    for (int k = 0; k < n; k++) begin
      if (awb + k < aw_addr_q.size())
        chk({name, "_awaddr"}, aw_addr_q[awb+k], (k < 4) ? 32'((k + 1) * 4) : 32'h0);
      if (wb + k < w_data_q.size())
        chk({name, "_wdata"}, w_data_q[wb+k], (k < 4) ? cfg[k*32 +: 32] : 32'h1);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_busy"}, busy_o, 0);
    chk({name, "_done"}, done_o, 0);
    chk({name, "_err"}, err_o, 0);
    chk({name, "_err_code"}, err_code_o, 0);
    chk({name, "_status"}, status_o, 0);
    chk({name, "_valids"}, {awvalid_o, wvalid_o, arvalid_o}, 0);
    chk({name, "_readys"}, {bready_o, rready_o}, 0);
    chk({name, "_awaddr"}, awaddr_o, 0);
    chk({name, "_wdata"}, wdata_o, 0);
    chk({name, "_wstrb"}, wstrb_o, 0);
    chk({name, "_araddr"}, araddr_o, 0);
  endtask

  typedef struct {
    logic [127:0] cfg;
    int           aw_lat;
    int           err_wr;
    int           done_at;
    logic         exp_done;
    logic [1:0]   exp_code;
    logic [2:0]   exp_status;
    int           exp_nwr;
    int           exp_nar;
  } vec_t;

  localparam logic [127:0] CFG_A = {32'hDDDD_0004, 32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
  localparam logic [127:0] CFG_B = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
  localparam logic [127:0] CFG_C = {32'h0BAD_F00D, 32'hCAFE_BABE, 32'h8000_0001, 32'h0000_0000};

  vec_t vecs[5];

  initial begin
    vecs[0] = '{CFG_A, 1, 0, 3, 1'b1, 2'd0, 3'd4, 5, 3};  // done on 3rd poll
    vecs[1] = '{CFG_B, 1, 2, 3, 1'b0, 2'd1, 3'd4, 2, 0};  // bresp error on 2nd write
    vecs[2] = '{CFG_A, 1, 0, 0, 1'b0, 2'd2, 3'd1, 5, 4};  // poll timeout
    vecs[3] = '{CFG_C, 2, 0, 1, 1'b1, 2'd0, 3'd4, 5, 1};  // done on 1st poll, slow AW
    vecs[4] = '{CFG_B, 1, 5, 1, 1'b0, 2'd1, 3'd4, 5, 0};  // trigger write rejected

    repeat (3) step();
    areset = 0;
    step();
    chk_reset_vals("rst");

    for (int r = 0; r < 5; r++) begin
      int aw0, w0, ar0, b0;
      aw_lat = vecs[r].aw_lat; err_wr = vecs[r].err_wr; done_at = vecs[r].done_at;
      aw0 = aw_addr_q.size(); w0 = w_data_q.size(); ar0 = ar_addr_q.size(); b0 = b_hs;
      run_job(vecs[r].cfg, "vec");
      chk("vec_done", done_o, vecs[r].exp_done);
      chk("vec_err", err_o, !vecs[r].exp_done);
      chk("vec_err_code", err_code_o, vecs[r].exp_code);
      chk("vec_status", status_o, vecs[r].exp_status);
      chk("vec_busy_end", busy_o, 0);
      step();
      chk("vec_pulse_len", {done_o, err_o}, 0);
      step(); step();
      chk("vec_n_aw", aw_addr_q.size() - aw0, vecs[r].exp_nwr);
      chk("vec_n_w", w_data_q.size() - w0, vecs[r].exp_nwr);
      chk("vec_n_b", b_hs - b0, vecs[r].exp_nwr);
      chk("vec_n_ar", ar_addr_q.size() - ar0, vecs[r].exp_nar);
      chk_writes("vec", aw0, w0, vecs[r].exp_nwr, vecs[r].cfg);
      for (int k = 0; k < vecs[r].exp_nar && ar0 + k < ar_addr_q.size(); k++) begin
        chk("vec_araddr", ar_addr_q[ar0+k], 32'h14);
        if (k > 0) chk("vec_ar_spacing", ar_cyc_q[ar0+k] - ar_cyc_q[ar0+k-1], 4);
      end
    end

    // AW ready three cycles late, W ready at once: one B per write
    begin
      int aw0, w0, b0;
      aw_lat = 3; err_wr = 0; done_at = 1;
      aw0 = aw_hi; w0 = w_hi; b0 = b_hs;
      run_job(CFG_C, "awdly");
      chk("awdly_done", done_o, 1);
      chk("awdly_awvalid_cycles", aw_hi - aw0, 15);
      chk("awdly_wvalid_cycles", w_hi - w0, 5);
      chk("awdly_n_b", b_hs - b0, 5);
    end

    // start held through a job while cfg_data_i changes underneath it
    begin
      int aw0, w0;
      aw_lat = 1; err_wr = 0; done_at = 2;
      aw0 = aw_addr_q.size(); w0 = w_data_q.size();
      step(); cfg_data_i = CFG_A; start_i = 1;
      step();
      chk("held_busy_rise", busy_o, 1);
      repeat (3) step();
      cfg_data_i = CFG_B;
      wait_end("held1");
      chk("held1_done", done_o, 1);
      chk("held1_n_aw", aw_addr_q.size() - aw0, 5);
      chk_writes("held1", aw0, w0, 5, CFG_A);
      step();
      chk("held_idle_busy", busy_o, 0);
      aw0 = aw_addr_q.size(); w0 = w_data_q.size();
      step();
      chk("held2_busy_rise", busy_o, 1);
      start_i = 0;
      wait_end("held2");
      chk("held2_done", done_o, 1);
      chk_writes("held2", aw0, w0, 5, CFG_B);
    end

    // asynchronous reset while waiting between polls, then a clean job
    begin
      int r0, ar0;
      bit seen = 0;
      aw_lat = 1; err_wr = 0; done_at = 0;
      step(); cfg_data_i = CFG_B; start_i = 1;
      step(); start_i = 0;
      r0 = r_hs;
      for (int i = 0; i < 200; i++) begin
        if (r_hs > r0) begin seen = 1; break; end
        step();
      end
      if (!seen) begin
        n_checks++; n_fail++;
        $display("FAIL arst_wait_timeout: no status read within 200 cycles");
      end
      step();
      chk("arst_pre_status", status_o, 1);
      chk("arst_pre_busy", busy_o, 1);
      areset = 1;
      #1;
      chk_reset_vals("arst");
      step(); step();
      areset = 0;
      step();
      done_at = 2;
      ar0 = ar_addr_q.size();
      run_job(CFG_A, "post");
      chk("post_done", done_o, 1);
      chk("post_err_code", err_code_o, 0);
      chk("post_status", status_o, 4);
      step();
      chk("post_n_ar", ar_addr_q.size() - ar0, 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
